// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: PC width, reset PC,
// fetch-sequencer state encoding and the 16-bit sign-extend helper.
package mips_pkg;

  localparam int unsigned PC_W_DEF = 30;
  localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = '0;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ifetch_target.sv
// Combinational redirect target: jump and branch word targets, jump has priority.
// Build option IFETCH_BR_SEQ_BASE_EN bases branches on the delay-slot word (pc+1).
module ifetch_target
  import mips_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            is_jump,
  input  logic [15:0]     imm16,
  input  logic [25:0]     addr26,
  input  logic [31:0]     redir_pc,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] br_base;
  logic [PC_W-1:0] br_tgt;
  logic            unused_pc_lsb;

  always_comb begin
    jump_tgt = PC_W'({redir_pc[31:28], addr26});
`ifdef IFETCH_BR_SEQ_BASE_EN
    br_base  = PC_W'(redir_pc[31:2]) + PC_W'(1);
`else
    br_base  = PC_W'(redir_pc[31:2]);
`endif
    // Truncating the 32-bit offset gives the modulo-2^PC_W wrap for free.
    br_tgt   = br_base + PC_W'(sext16(imm16));
    target   = is_jump ? jump_tgt : br_tgt;
  end

  assign unused_pc_lsb = ^redir_pc[1:0];

endmodule

// File: rtl/ifetch_seq.sv
// Fetch sequencer: owns the PC, runs one outstanding imem req/ack fetch and feeds
// decode through a one-entry valid/ready buffer. Branch base option: IFETCH_BR_SEQ_BASE_EN.
module ifetch_seq
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] redir_pc
);

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            buf_valid_q, buf_valid_d;
  logic [31:0]     buf_data_q, buf_data_d;
  logic [31:0]     buf_pc_q, buf_pc_d;
  logic [31:0]     hold_data_q, hold_data_d;
  logic [31:0]     hold_pc_q, hold_pc_d;

  logic [PC_W-1:0] redir_tgt;
  logic [31:0]     pc_byte;
  logic            redir_take;
  logic            ack;
  logic            pop;

  ifetch_target #(.PC_W(PC_W)) u_target (
    .is_jump  (is_jump),
    .imm16    (imm16),
    .addr26   (addr26),
    .redir_pc (redir_pc),
    .target   (redir_tgt)
  );

  assign pc_byte    = 32'({pc_q, 2'b00});
  assign redir_take = redirect & (is_jump | is_branch);
  assign ack        = imem_ack & req_q;
  assign pop        = buf_valid_q & inst_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_valid_d = buf_valid_q & ~pop;
    buf_data_d  = buf_data_q;
    buf_pc_d    = buf_pc_q;
    hold_data_d = hold_data_q;
    hold_pc_d   = hold_pc_q;

    case (state_q)
      ST_FETCH: begin
        if (ack) begin
          pc_d = pc_q + PC_W'(1);
          if (!buf_valid_q || pop) begin
            buf_valid_d = 1'b1;
            buf_data_d  = imem_rdata;
            buf_pc_d    = pc_byte;
          end else begin
            hold_data_d = imem_rdata;
            hold_pc_d   = pc_byte;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (pop) begin
          buf_valid_d = 1'b1;
          buf_data_d  = hold_data_q;
          buf_pc_d    = hold_pc_q;
          state_d     = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (ack) begin
          pc_d    = tgt_q;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    // A redirect flushes everything; an unfinished fetch must still be drained
    // with its address held, so the target waits in tgt_q until the ack.
    if (redir_take) begin
      buf_valid_d = 1'b0;
      if (req_q && !ack) begin
        state_d = ST_DRAIN;
        tgt_d   = redir_tgt;
        pc_d    = pc_q;
      end else begin
        state_d = ST_FETCH;
        pc_d    = redir_tgt;
      end
    end

    req_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      req_q       <= 1'b0;
      pc_q        <= RESET_PC;
      tgt_q       <= RESET_PC;
      buf_valid_q <= 1'b0;
      // NOTE: data registers are reset too because decode sees inst_data/inst_pc as 0 out of reset.
      buf_data_q  <= '0;
      buf_pc_q    <= '0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      req_q       <= req_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_pc_q    <= buf_pc_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_byte;
  assign inst_valid = buf_valid_q;
  assign inst_data  = buf_data_q;
  assign inst_pc    = buf_pc_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Self-checking bench for ifetch_seq: directed scenarios then a randomized run,
// scored against an in-order instruction-stream model and a latency-driven memory.
module tb_ifetch_seq;

`ifdef IFETCH_BR_SEQ_BASE_EN
  localparam logic [31:0] BR_INC = 32'd1;
`else
  localparam logic [31:0] BR_INC = 32'd0;
`endif
  localparam logic [31:0] T4_EXP_ADDR = (BR_INC != 0) ? 32'h0000_001C : 32'h0000_0018;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect;
  logic        is_jump;
  logic        is_branch;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] redir_pc;

  ifetch_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .redirect   (redirect),
    .is_jump    (is_jump),
    .is_branch  (is_branch),
    .imm16      (imm16),
    .addr26     (addr26),
    .redir_pc   (redir_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: program-order stream plus a simple memory responder.
  logic [31:0] exp_pc;
  bit          mem_pending;
  int          mem_wait;
  int          lat_max;
  bit          lat_rand;
  bit          spurious_en;
  bit          late_ack;
  bit          prev_open;
  logic [31:0] prev_addr;
  bit          prev_held;
  logic [31:0] prev_data;
  logic [31:0] prev_ipc;
  bit          prev_redir;
  bit          tgt_chk;
  logic [31:0] tgt_addr;
  int          pops;
  int          acks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] model_target(input logic j, input logic [31:0] rpc,
                                               input logic [25:0] a26, input logic [15:0] i16);
    logic [31:0] word;
    logic [31:0] off;
    if (j) return {rpc[31:28], a26, 2'b00};
    word = rpc >> 2;
    off  = {{16{i16[15]}}, i16};
    return (word + BR_INC + off) << 2;
  endfunction

  task automatic reset_model();
    exp_pc      = 32'h0;
    mem_pending = 1'b0;
    mem_wait    = 0;
    prev_open   = 1'b0;
    prev_held   = 1'b0;
    prev_redir  = 1'b0;
    tgt_chk     = 1'b1;
    tgt_addr    = 32'h0;
  endtask

  // Called at a negedge with stimulus set; scores this cycle, advances one clock.
  task automatic tick();
    logic [31:0] t;
    bit          eff;
    if (prev_open) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, prev_addr);
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (imem_req) begin
      if (!mem_pending) begin
        mem_pending = 1'b1;
        mem_wait    = lat_rand ? int'($urandom_range(lat_max, 0)) : lat_max;
        if (tgt_chk) begin
          check("fetch_start_addr", imem_addr, tgt_addr);
          tgt_chk = 1'b0;
        end
      end
      if (mem_wait == 0) begin
        imem_ack    = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        mem_pending = 1'b0;
        acks++;
      end else begin
        mem_wait--;
      end
    end else begin
      imem_ack = late_ack | (spurious_en & ($urandom_range(1, 0) == 1));
    end
    prev_open = imem_req && !imem_ack;
    prev_addr = imem_addr;

    if (prev_redir) begin
      check("valid_low_after_redirect", 32'(inst_valid), 32'd0);
    end else if (prev_held) begin
      check("valid_kept", 32'(inst_valid), 32'd1);
      check("data_kept", inst_data, prev_data);
      check("pc_kept", inst_pc, prev_ipc);
    end
    if (inst_valid && inst_ready) begin
      check("pop_pc", inst_pc, exp_pc);
      check("pop_data", inst_data, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    eff = redirect && (is_jump || is_branch);
    if (eff) begin
      t        = model_target(is_jump, redir_pc, addr26, imm16);
      exp_pc   = t;
      tgt_chk  = 1'b1;
      tgt_addr = t;
    end
    prev_held  = inst_valid && !inst_ready && !eff;
    prev_data  = inst_data;
    prev_ipc   = inst_pc;
    prev_redir = eff;

    @(posedge clk);
    @(negedge clk);
    redirect  = 1'b0;
    is_jump   = 1'b0;
    is_branch = 1'b0;
    late_ack  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic wait_outstanding(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req && mem_pending && mem_wait > 0) found = 1'b1;
      else tick();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int acks0;
    int pops0;
    bit found;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    redirect = 1'b0; is_jump = 1'b0; is_branch = 1'b0;
    imm16 = '0; addr26 = '0; redir_pc = '0;
    lat_max = 0; lat_rand = 1'b0; spurious_en = 1'b0; late_ack = 1'b0;
    pops = 0; acks = 0;
    reset_model();

    repeat (2) @(negedge clk);
    check("reset_req", 32'(imem_req), 32'd0);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_data", inst_data, 32'd0);
    check("reset_pc", inst_pc, 32'd0);
    check("reset_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
    reset_model();

    // 1: zero-wait memory, decode always ready
    inst_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t1_addr", imem_addr, 32'(i * 4));
      if (i > 0) check("t1_no_bubble", 32'(inst_valid), 32'd1);
      tick();
    end

    // 2: 3-cycle memory, decode stalled -> one buffered word, one held word, then idle
    do_reset();
    lat_max = 3; inst_ready = 1'b0;
    acks0 = acks;
    repeat (20) tick();
    check("t2_fetch_count", 32'(acks - acks0), 32'd2);
    check("t2_req_idle", 32'(imem_req), 32'd0);
    check("t2_valid", 32'(inst_valid), 32'd1);
    check("t2_inst_pc", inst_pc, 32'd0);
    inst_ready = 1'b1;
    repeat (12) tick();

    // 3: jump with nothing outstanding
    lat_max = 0; inst_ready = 1'b0;
    repeat (8) tick();
    check("t3_idle", 32'(imem_req), 32'd0);
    redirect = 1'b1; is_jump = 1'b1; redir_pc = 32'h1000_0040; addr26 = 26'h000_0100;
    tick();
    check("t3_addr", imem_addr, 32'h1000_0400);
    check("t3_req", 32'(imem_req), 32'd1);
    inst_ready = 1'b1;
    repeat (6) tick();

    // 4: taken branch while a fetch is in flight -> drain, then fetch at target
    lat_max = 3;
    wait_outstanding("t4_outstanding");
    redirect = 1'b1; is_branch = 1'b1; redir_pc = 32'h0000_0020; imm16 = 16'hFFFE;
    tick();
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (imem_req && !mem_pending) found = 1'b1;
      else tick();
    end
    check("t4_refetch_seen", 32'(found), 32'd1);
    check("t4_addr", imem_addr, T4_EXP_ADDR);
    repeat (10) tick();

    // 5: redirect with both kinds set, in the same cycle as a zero-wait ack
    lat_max = 0;
    repeat (2) tick();
    check("t5_req_new", 32'({imem_req, mem_pending}), 32'd2);
    redirect = 1'b1; is_jump = 1'b1; is_branch = 1'b1;
    redir_pc = 32'h2000_0000; addr26 = 26'h000_0040; imm16 = 16'h0010;
    tick();
    check("t5_addr", imem_addr, 32'h2000_0100);
    check("t5_req", 32'(imem_req), 32'd1);
    repeat (4) tick();

    // 6: PC wrap, then reset in the middle of a fetch with a late ack
    redirect = 1'b1; is_jump = 1'b1; redir_pc = 32'hF000_0000; addr26 = 26'h3FF_FFFF;
    tick();
    check("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_addr", imem_addr, 32'h0000_0000);
    repeat (3) tick();
    lat_max = 3;
    wait_outstanding("t6_outstanding");
    do_reset();
    late_ack = 1'b1;
    tick();
    lat_max = 0;
    repeat (6) tick();

    // Randomized run: variable latency, random stalls, random redirects
    lat_max = 3; lat_rand = 1'b1; spurious_en = 1'b1;
    pops0 = pops;
    for (int i = 0; i < 1500; i++) begin
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        redirect  = 1'b1;
        is_jump   = $urandom_range(1, 0) == 1;
        is_branch = $urandom_range(1, 0) == 1;
        imm16     = 16'($urandom);
        addr26    = 26'($urandom);
        redir_pc  = $urandom;
      end
      tick();
    end
    check("rand_progress", 32'(pops - pops0 >= 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
